sysbus_arbiter: RTL and testbench

SYSBUS_ARBITER -- requirements
Module: sysbus_arbiter

---
 rtl/sysbus_arbiter_if.sv | 39 +++
 rtl/sysbus_arbiter.sv | 97 +++++++++
 tb/tb_sysbus_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sysbus_arbiter_if.sv
// Bundle of client-side and Sysbus-side signals around the two-client arbiter.
// master = arbiter view, slave = view of the clients plus the Sysbus memory side.
interface sysbus_arbiter_if #(
    parameter int TAGW = 13
);
    logic [1:0]           c_reqcyc;
    logic [1:0][63:0]     c_req;
    logic [1:0][TAGW-1:0] c_reqtag;
    logic [1:0]           c_reqack;
    logic [1:0]           c_respcyc;
    logic [63:0]          c_resp;

    logic                 reqcyc;
    logic [63:0]          req;
    logic [TAGW-1:0]      reqtag;
    logic                 reqack;
    logic                 respcyc;
    logic [63:0]          resp;
    logic [TAGW-1:0]      resptag;
    logic                 respack;

    modport master (
        input  c_reqcyc, c_req, c_reqtag,
        output c_reqack, c_respcyc, c_resp,
        output reqcyc, req, reqtag,
        input  reqack,
        input  respcyc, resp, resptag,
        output respack
    );

    modport slave (
        output c_reqcyc, c_req, c_reqtag,
        input  c_reqack, c_respcyc, c_resp,
        input  reqcyc, req, reqtag,
        output reqack,
        output respcyc, resp, resptag,
        input  respack
    );
endinterface

// File: rtl/sysbus_arbiter.sv
// Two-client (ifetch / dmem) round-robin arbiter onto a single Sysbus port,
// one transaction outstanding at a time.
module sysbus_arbiter #(
    parameter int BEATS = 8,
    parameter int TAGW  = 13
) (
    input  logic            clk,
    input  logic            reset,
    sysbus_arbiter_if.master bus
);
    localparam int CW = $clog2(BEATS) + 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WDATA, WAIT, RESP} state_t;

    state_t          state, state_nx;
    logic            grant;
    logic            last_grant;
    logic            pick;
    logic [63:0]     req_q;
    logic [TAGW-1:0] reqtag_q;
    logic [CW-1:0]   beat_cnt;
    logic            is_write;
    logic            unused_bits;

    // Tag MSB is the Sysbus READ flag: 1 = read, 0 = write.
    assign is_write = (reqtag_q[TAGW-1] == 1'b0);

    assign unused_bits = ^{bus.resptag[TAGW-1:1], bus.c_reqtag[0][7:0], bus.c_reqtag[1][7:0]};

    always_comb begin
        if (&bus.c_reqcyc) pick = ~last_grant;
        else               pick = bus.c_reqcyc[1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            req_q      <= '0;
            reqtag_q   <= '0;
            beat_cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && |bus.c_reqcyc) begin
                grant      <= pick;
                last_grant <= pick;
                req_q      <= bus.c_req[pick];
                reqtag_q   <= {bus.c_reqtag[pick][TAGW-1:8], 7'b0, pick};
            end
            // Saturating beat counter; cleared whenever we are outside WDATA.
            if (state == WDATA) begin
                if (beat_cnt < CW'(BEATS)) beat_cnt <= beat_cnt + 1'b1;
            end else begin
                beat_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        bus.reqcyc    = 1'b0;
        bus.req       = req_q;
        bus.reqtag    = reqtag_q;
        bus.c_reqack  = 2'b00;
        bus.c_respcyc = 2'b00;
        bus.c_resp    = bus.resp;
        bus.respack   = bus.respcyc;
        case (state)
            IDLE: begin
                if (|bus.c_reqcyc) state_nx = ISSUE;
            end
            ISSUE: begin
                bus.reqcyc = 1'b1;
                if (bus.reqack) begin
                    bus.c_reqack[grant] = 1'b1;
                    state_nx = is_write ? WDATA : WAIT;
                end
            end
            WDATA: begin
                // Write beats stream straight from the client, no stalls.
                bus.reqcyc = 1'b1;
                bus.req    = bus.c_req[grant];
                if (beat_cnt == CW'(BEATS - 1)) state_nx = WAIT;
            end
            WAIT: begin
                bus.c_respcyc[bus.resptag[0]] = bus.respcyc;
                if (bus.respcyc && bus.resptag[0] == grant) state_nx = RESP;
            end
            RESP: begin
                bus.c_respcyc[bus.resptag[0]] = bus.respcyc;
                if (!bus.respcyc) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: reset, reads, round-robin order, write
// beats, async reset mid-response, stray responses and early request drop.
module tb_sysbus_arbiter;
    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    sysbus_arbiter_if #(.TAGW(13)) bus ();

    sysbus_arbiter #(.BEATS(8), .TAGW(13)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one transaction from IDLE with the request(s) already driven.
    task automatic do_txn(input int cl, input bit wr, input logic [63:0] addr,
                          input logic [12:0] tag, input int wait_cyc, input int rbeats,
                          input bit drop_early, input logic [63:0] dbase);
        logic [1:0] onehot;
        onehot = (cl == 1) ? 2'b10 : 2'b01;
        tick();
        if (drop_early) bus.c_reqcyc[cl] = 1'b0;
        settle();
        chk("grant_reqcyc", bus.reqcyc, 1);
        chk("grant_req", bus.req, addr);
        chk("grant_tag", bus.reqtag, tag);
        chk("grant_noack", bus.c_reqack, 0);
        repeat (wait_cyc) begin
            tick();
            settle();
            chk("issue_reqcyc", bus.reqcyc, 1);
            chk("issue_req", bus.req, addr);
            chk("issue_noack", bus.c_reqack, 0);
        end
        tick();
        bus.reqack = 1'b1;
        settle();
        chk("ack_reqcyc", bus.reqcyc, 1);
        chk("ack_pulse", bus.c_reqack, onehot);
        tick();
        bus.reqack      = 1'b0;
        bus.c_reqcyc[cl] = 1'b0;
        settle();
        chk("ack_once", bus.c_reqack, 0);
        if (wr) begin
            for (int b = 0; b < 8; b++) begin
                bus.c_req[cl] = dbase + 64'(b);
                settle();
                chk("wdata_reqcyc", bus.reqcyc, 1);
                chk("wdata_req", bus.req, dbase + 64'(b));
                tick();
            end
            settle();
        end
        chk("wait_reqcyc", bus.reqcyc, 0);
        for (int b = 0; b < rbeats; b++) begin
            bus.respcyc = 1'b1;
            bus.resp    = 64'hD000 + 64'(b);
            bus.resptag = tag;
            settle();
            chk("resp_cyc", bus.c_respcyc, onehot);
            chk("resp_data", bus.c_resp, 64'hD000 + 64'(b));
            chk("resp_ack", bus.respack, 1);
            tick();
        end
        bus.respcyc = 1'b0;
        settle();
        chk("resp_end", bus.c_respcyc, 0);
        chk("respack_low", bus.respack, 0);
        tick();
        settle();
        chk("back_idle", 64'(dut.state), 0);
    endtask

    initial begin
        reset        = 1'b1;
        bus.c_reqcyc = 2'b00;
        bus.c_req    = '0;
        bus.c_reqtag = '0;
        bus.reqack   = 1'b0;
        bus.respcyc  = 1'b0;
        bus.resp     = '0;
        bus.resptag  = '0;

        // Reset state
        tick();
        tick();
        chk("rst_reqcyc", bus.reqcyc, 0);
        chk("rst_req", bus.req, 0);
        chk("rst_reqtag", bus.reqtag, 0);
        chk("rst_reqack", bus.c_reqack, 0);
        chk("rst_respcyc", bus.c_respcyc, 0);
        reset = 1'b0;
        settle();
        chk("rel_reqcyc", bus.reqcyc, 0);

        // Single read, client 0, reqack in third issue cycle, 8 beats
        bus.c_reqcyc    = 2'b01;
        bus.c_req[0]    = 64'h1000;
        bus.c_reqtag[0] = 13'h11FF;
        do_txn(0, 1'b0, 64'h1000, 13'h1100, 1, 8, 1'b0, 64'h0);

        // Reset during the 4th response beat of a read
        bus.c_reqcyc    = 2'b01;
        bus.c_req[0]    = 64'h1040;
        bus.c_reqtag[0] = 13'h1100;
        tick();
        bus.reqack = 1'b1;
        tick();
        bus.reqack   = 1'b0;
        bus.c_reqcyc = 2'b00;
        for (int b = 0; b < 4; b++) begin
            bus.respcyc = 1'b1;
            bus.resp    = 64'(b);
            bus.resptag = 13'h1100;
            if (b < 3) tick();
        end
        settle();
        chk("mid_respcyc", bus.c_respcyc, 2'b01);
        reset = 1'b1;
        settle();
        chk("async_respcyc", bus.c_respcyc, 0);
        chk("async_reqcyc", bus.reqcyc, 0);
        chk("async_req", bus.req, 0);
        chk("async_state", 64'(dut.state), 0);
        bus.respcyc = 1'b0;
        tick();
        reset = 1'b0;
        settle();
        chk("rel2_reqcyc", bus.reqcyc, 0);
        tick();
        chk("rel2_idle", bus.reqcyc, 0);

        // Round robin: both request twice -> order 0,1,0,1
        bus.c_reqcyc    = 2'b11;
        bus.c_req[0]    = 64'h3000;
        bus.c_req[1]    = 64'h4000;
        bus.c_reqtag[0] = 13'h1155;
        bus.c_reqtag[1] = 13'h1155;
        do_txn(0, 1'b0, 64'h3000, 13'h1100, 0, 8, 1'b0, 64'h0);
        do_txn(1, 1'b0, 64'h4000, 13'h1101, 0, 8, 1'b0, 64'h0);
        bus.c_reqcyc = 2'b11;
        do_txn(0, 1'b0, 64'h3000, 13'h1100, 0, 8, 1'b0, 64'h0);
        do_txn(1, 1'b0, 64'h4000, 13'h1101, 0, 8, 1'b0, 64'h0);

        // Write, client 1, data A0..A7, one response beat
        bus.c_reqcyc    = 2'b10;
        bus.c_req[1]    = 64'h2000;
        bus.c_reqtag[1] = 13'h0133;
        do_txn(1, 1'b1, 64'h2000, 13'h0101, 1, 1, 1'b0, 64'hA0);

        // Stray response while IDLE
        bus.respcyc = 1'b1;
        bus.resp    = 64'hBAD;
        bus.resptag = 13'h1101;
        settle();
        chk("stray_respack", bus.respack, 1);
        chk("stray_respcyc", bus.c_respcyc, 0);
        tick();
        chk("stray_idle", 64'(dut.state), 0);
        chk("stray_reqcyc", bus.reqcyc, 0);
        bus.respcyc = 1'b0;
        tick();

        // Client 0 drops its request right after grant
        bus.c_reqcyc    = 2'b01;
        bus.c_req[0]    = 64'h5000;
        bus.c_reqtag[0] = 13'h1100;
        do_txn(0, 1'b0, 64'h5000, 13'h1100, 2, 8, 1'b1, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
